// File: rtl/tr_seq_pkg.sv
// ---------------------------------------------------------------------------
// tr_seq_pkg
// Shared definitions for the toggle-rate sequencer:
//   - tr_state_t       : sequencer states (idle, load-reset pulse, ramp up,
//                        hold at target, ramp down)
//   - MAX_RATE_DEFAULT : default toggle-rate ceiling in percent
// ---------------------------------------------------------------------------
package tr_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRERST = 3'd1,
      ST_UP     = 3'd2,
      ST_HOLD   = 3'd3,
      ST_DOWN   = 3'd4
   } tr_state_t;

   localparam int MAX_RATE_DEFAULT = 100;

endpackage

// File: rtl/tr_dwell_timer.sv
// ---------------------------------------------------------------------------
// tr_dwell_timer
// Loadable down-counter used for both the load-reset pulse length and the
// per-step dwell. A value L written with `load` makes `expire` rise exactly
// L cycles later (in the cycle where the count reads 1). Once it reaches 0
// the counter parks there until the next load.
//
// Ports
//   clk        in   1        clock
//   rst        in   1        async active-high reset
//   clear      in   1        synchronous clear to 0 (wins over load)
//   load       in   1        load `load_value` into the counter
//   load_value in   DWELL_W  value to load (>= 1 for a meaningful interval)
//   expire     out  1        high in the last cycle of the loaded interval
// ---------------------------------------------------------------------------
module tr_dwell_timer #(
   parameter int DWELL_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               load,
   input  logic [DWELL_W-1:0] load_value,
   output logic               expire
);

   localparam logic [DWELL_W-1:0] CNT_ZERO = DWELL_W'(0);
   localparam logic [DWELL_W-1:0] CNT_ONE  = DWELL_W'(1);

   logic [DWELL_W-1:0] count_r;

   // Down-counter: clear > load > decrement, parking at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= CNT_ZERO;
      end else if (clear) begin
         count_r <= CNT_ZERO;
      end else if (load) begin
         count_r <= load_value;
      end else if (count_r != CNT_ZERO) begin
         count_r <= count_r - CNT_ONE;
      end else begin
         count_r <= count_r;
      end
   end

   assign expire = (count_r == CNT_ONE);

endmodule

// File: rtl/toggle_rate_sequencer.sv
// ---------------------------------------------------------------------------
// toggle_rate_sequencer
// Drives the shared rst / TOGGLE_RATE pins of the power-measurement activity
// loads from a programmed profile: pulse the load reset, ramp the toggle rate
// up to a target in fixed steps (each step held for a dwell), hold there, and
// ramp back down when asked.
//
// Ports
//   clk          in   1        load clock
//   rst          in   1        async active-high reset
//   start        in   1        level; rising edge starts a sequence (IDLE only)
//   stop         in   1        level; rising edge ramps down (UP / HOLD only)
//   abort        in   1        level; while high the block returns to IDLE
//   target_rate  in   RATE_W   final rate in percent (clamped to MAX_RATE)
//   step_rate    in   RATE_W   rate change per step (0 treated as 1)
//   dwell_cycles in   DWELL_W  cycles spent at each rate (0 treated as 1)
//   toggle_rate  out  RATE_W   to the loads' TOGGLE_RATE
//   load_rst     out  1        to the loads' rst
//   busy         out  1        any state other than IDLE
//   at_target    out  1        in HOLD
//   done         out  1        one-cycle pulse on entry to HOLD
// ---------------------------------------------------------------------------
module toggle_rate_sequencer
   import tr_seq_pkg::*;
#(
   parameter int RATE_W   = 7,
   parameter int MAX_RATE = MAX_RATE_DEFAULT,
   parameter int DWELL_W  = 32,
   parameter int RST_HOLD = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               abort,
   input  logic [RATE_W-1:0]  target_rate,
   input  logic [RATE_W-1:0]  step_rate,
   input  logic [DWELL_W-1:0] dwell_cycles,
   output logic [RATE_W-1:0]  toggle_rate,
   output logic               load_rst,
   output logic               busy,
   output logic               at_target,
   output logic               done
);

   // Ceiling limited to what RATE_W can represent, so the clamp never wraps.
   localparam int                 RATE_CODE_MAX = (1 << RATE_W) - 1;
   localparam int                 CEIL_INT      = (MAX_RATE > RATE_CODE_MAX) ? RATE_CODE_MAX : MAX_RATE;
   localparam logic [RATE_W:0]    CEIL_WIDE     = (RATE_W+1)'(CEIL_INT);
   localparam logic [RATE_W-1:0]  RATE_ZERO     = RATE_W'(0);
   localparam logic [RATE_W-1:0]  RATE_ONE      = RATE_W'(1);
   localparam logic [DWELL_W-1:0] DWELL_ZERO    = DWELL_W'(0);
   localparam logic [DWELL_W-1:0] DWELL_ONE     = DWELL_W'(1);
   localparam logic [DWELL_W-1:0] RST_LOAD      = DWELL_W'(RST_HOLD);

   // Saturating increment: a + b computed one bit wider, limited to ceil.
   function automatic logic [RATE_W-1:0] sat_add(input logic [RATE_W-1:0] a,
                                                  input logic [RATE_W-1:0] b,
                                                  input logic [RATE_W-1:0] ceil);
      logic [RATE_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum > {1'b0, ceil}) begin
         sat_add = ceil;
      end else begin
         sat_add = sum[RATE_W-1:0];
      end
   endfunction

   // Saturating decrement: a borrow shows up in the extra top bit -> floor at 0.
   function automatic logic [RATE_W-1:0] sat_sub(input logic [RATE_W-1:0] a,
                                                  input logic [RATE_W-1:0] b);
      logic [RATE_W:0] diff;
      diff = {1'b0, a} - {1'b0, b};
      if (diff[RATE_W]) begin
         sat_sub = RATE_ZERO;
      end else begin
         sat_sub = diff[RATE_W-1:0];
      end
   endfunction

   // Registered state and outputs
   tr_state_t          state_r;
   logic [RATE_W-1:0]  rate_r;
   logic               load_rst_r;
   logic               busy_r;
   logic               at_target_r;
   logic               done_r;

   // Edge detection and latched command
   logic               start_q_r;
   logic               stop_q_r;
   logic [RATE_W-1:0]  target_r;
   logic [RATE_W-1:0]  step_r;
   logic [DWELL_W-1:0] dwell_r;

   // Next-state / combinational helpers
   tr_state_t          state_s;
   logic [RATE_W-1:0]  rate_s;
   logic               load_rst_s;
   logic               done_s;
   logic               latch_s;
   logic               tmr_load_s;
   logic               tmr_clear_s;
   logic [DWELL_W-1:0] tmr_value_s;
   logic               tmr_expire_s;
   logic               start_edge_s;
   logic               stop_edge_s;
   logic               stop_take_s;
   logic [RATE_W-1:0]  tgt_in_s;
   logic [RATE_W-1:0]  stp_in_s;
   logic [DWELL_W-1:0] dwl_in_s;
   logic [RATE_W-1:0]  rate_up_s;
   logic [RATE_W-1:0]  rate_dn_s;
   logic [RATE_W-1:0]  first_rate_s;

   assign start_edge_s = start & ~start_q_r;
   assign stop_edge_s  = stop & ~stop_q_r;
   // Stop only has meaning while ramping up or holding.
   assign stop_take_s  = stop_edge_s & ((state_r == ST_UP) | (state_r == ST_HOLD));

   assign rate_up_s    = sat_add(rate_r, step_r, target_r);
   assign rate_dn_s    = sat_sub(rate_r, step_r);
   assign first_rate_s = (step_r < target_r) ? step_r : target_r;

   tr_dwell_timer #(
      .DWELL_W    (DWELL_W)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .clear      (tmr_clear_s),
      .load       (tmr_load_s),
      .load_value (tmr_value_s),
      .expire     (tmr_expire_s)
   );

   // Command sanitising: clamp the target, promote zero step / zero dwell to 1.
   always_comb begin
      tgt_in_s = target_rate;
      stp_in_s = step_rate;
      dwl_in_s = dwell_cycles;
      if ({1'b0, target_rate} > CEIL_WIDE) begin
         tgt_in_s = CEIL_WIDE[RATE_W-1:0];
      end else begin
         tgt_in_s = target_rate;
      end
      if (step_rate == RATE_ZERO) begin
         stp_in_s = RATE_ONE;
      end else begin
         stp_in_s = step_rate;
      end
      if (dwell_cycles == DWELL_ZERO) begin
         dwl_in_s = DWELL_ONE;
      end else begin
         dwl_in_s = dwell_cycles;
      end
   end

   // Input edge-detect copies, sampled every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q_r <= 1'b0;
         stop_q_r  <= 1'b0;
      end else begin
         start_q_r <= start;
         stop_q_r  <= stop;
      end
   end

   // Command latch, written only when a start edge is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         target_r <= RATE_ZERO;
         step_r   <= RATE_ZERO;
         dwell_r  <= DWELL_ZERO;
      end else if (latch_s) begin
         target_r <= tgt_in_s;
         step_r   <= stp_in_s;
         dwell_r  <= dwl_in_s;
      end else begin
         target_r <= target_r;
         step_r   <= step_r;
         dwell_r  <= dwell_r;
      end
   end

   // Next-state and next-output logic; priority abort > stop > dwell expiry.
   always_comb begin
      state_s     = state_r;
      rate_s      = rate_r;
      load_rst_s  = 1'b0;
      done_s      = 1'b0;
      latch_s     = 1'b0;
      tmr_load_s  = 1'b0;
      tmr_clear_s = 1'b0;
      tmr_value_s = dwell_r;

      if (abort) begin
         state_s     = ST_IDLE;
         rate_s      = RATE_ZERO;
         tmr_clear_s = 1'b1;
      end else if (stop_take_s) begin
         // Ramp-down starts from the current rate; nothing to do at zero.
         if (rate_r == RATE_ZERO) begin
            state_s     = ST_IDLE;
            rate_s      = RATE_ZERO;
            tmr_clear_s = 1'b1;
         end else begin
            state_s    = ST_DOWN;
            rate_s     = rate_dn_s;
            tmr_load_s = 1'b1;
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               rate_s = RATE_ZERO;
               if (start_edge_s) begin
                  state_s     = ST_PRERST;
                  load_rst_s  = 1'b1;
                  latch_s     = 1'b1;
                  tmr_load_s  = 1'b1;
                  tmr_value_s = RST_LOAD;
               end else begin
                  state_s = ST_IDLE;
               end
            end

            ST_PRERST: begin
               rate_s = RATE_ZERO;
               if (tmr_expire_s) begin
                  // A zero target skips the ramp and lands straight in HOLD.
                  if (target_r == RATE_ZERO) begin
                     state_s = ST_HOLD;
                     done_s  = 1'b1;
                  end else begin
                     state_s    = ST_UP;
                     rate_s     = first_rate_s;
                     tmr_load_s = 1'b1;
                  end
               end else begin
                  load_rst_s = 1'b1;
               end
            end

            ST_UP: begin
               if (tmr_expire_s) begin
                  if (rate_r < target_r) begin
                     rate_s     = rate_up_s;
                     tmr_load_s = 1'b1;
                  end else begin
                     state_s = ST_HOLD;
                     done_s  = 1'b1;
                  end
               end else begin
                  state_s = ST_UP;
               end
            end

            ST_HOLD: begin
               state_s = ST_HOLD;
            end

            ST_DOWN: begin
               if (tmr_expire_s) begin
                  if (rate_r == RATE_ZERO) begin
                     state_s = ST_IDLE;
                  end else begin
                     rate_s     = rate_dn_s;
                     tmr_load_s = 1'b1;
                  end
               end else begin
                  state_s = ST_DOWN;
               end
            end

            default: begin
               state_s     = ST_IDLE;
               rate_s      = RATE_ZERO;
               tmr_clear_s = 1'b1;
            end
         endcase
      end
   end

   // State and output registers; status flags are derived from the next state
   // so they line up with the registered rate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         rate_r      <= RATE_ZERO;
         load_rst_r  <= 1'b0;
         busy_r      <= 1'b0;
         at_target_r <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         rate_r      <= rate_s;
         load_rst_r  <= load_rst_s;
         busy_r      <= (state_s != ST_IDLE);
         at_target_r <= (state_s == ST_HOLD);
         done_r      <= done_s;
      end
   end

   assign toggle_rate = rate_r;
   assign load_rst    = load_rst_r;
   assign busy        = busy_r;
   assign at_target   = at_target_r;
   assign done        = done_r;

endmodule

// File: tb/tb_toggle_rate_sequencer.sv
// ---------------------------------------------------------------------------
// tb_toggle_rate_sequencer
// Directed profile scenarios followed by randomized command traffic. The
// reference model turns each accepted command into a queue of per-cycle
// expected outputs (schedule of rates), which is replayed cycle by cycle.
// ---------------------------------------------------------------------------
module tb_toggle_rate_sequencer;

   localparam int RATE_W   = 7;
   localparam int MAX_RATE = 100;
   localparam int DWELL_W  = 32;
   localparam int RST_HOLD = 4;

   localparam int K_IDLE = 0;
   localparam int K_PRE  = 1;
   localparam int K_UP   = 2;
   localparam int K_HOLD = 3;
   localparam int K_DOWN = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               stop;
   logic               abort;
   logic [RATE_W-1:0]  target_rate;
   logic [RATE_W-1:0]  step_rate;
   logic [DWELL_W-1:0] dwell_cycles;
   logic [RATE_W-1:0]  toggle_rate;
   logic               load_rst;
   logic               busy;
   logic               at_target;
   logic               done;

   int n_checks = 0;
   int n_errors = 0;

   toggle_rate_sequencer #(
      .RATE_W   (RATE_W),
      .MAX_RATE (MAX_RATE),
      .DWELL_W  (DWELL_W),
      .RST_HOLD (RST_HOLD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .abort        (abort),
      .target_rate  (target_rate),
      .step_rate    (step_rate),
      .dwell_cycles (dwell_cycles),
      .toggle_rate  (toggle_rate),
      .load_rst     (load_rst),
      .busy         (busy),
      .at_target    (at_target),
      .done         (done)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      int rate;
      int kind;
      bit pulse;
   } ent_t;

   ent_t plan[$];
   ent_t cur;
   bit   prev_start;
   bit   prev_stop;
   int   m_tgt;
   int   m_stp;
   int   m_dwl;

   int up_exp[9]   = '{4, 4, 4, 8, 8, 8, 10, 10, 10};
   int down_exp[9] = '{6, 6, 6, 2, 2, 2, 0, 0, 0};

   function automatic void model_reset();
      plan.delete();
      cur        = '{0, K_IDLE, 1'b0};
      prev_start = 1'b0;
      prev_stop  = 1'b0;
   endfunction

   function automatic void model_step();
      bit se;
      bit pe;
      bit stopped;
      int r;
      se = start && !prev_start;
      pe = stop && !prev_stop;
      prev_start = start;
      prev_stop  = stop;
      stopped = 1'b0;
      if (abort) begin
         plan.delete();
         cur = '{0, K_IDLE, 1'b0};
         return;
      end
      if ((cur.kind == K_UP || cur.kind == K_HOLD) && pe) begin
         stopped = 1'b1;
         plan.delete();
         r = cur.rate;
         while (r > 0) begin
            r = (r > m_stp) ? r - m_stp : 0;
            repeat (m_dwl) plan.push_back('{r, K_DOWN, 1'b0});
         end
      end else if (cur.kind == K_IDLE && se) begin
         m_tgt = (int'(target_rate) > MAX_RATE) ? MAX_RATE : int'(target_rate);
         m_stp = (step_rate == 0) ? 1 : int'(step_rate);
         m_dwl = (dwell_cycles == 0) ? 1 : int'(dwell_cycles);
         plan.delete();
         repeat (RST_HOLD) plan.push_back('{0, K_PRE, 1'b0});
         r = (m_stp < m_tgt) ? m_stp : m_tgt;
         while (m_tgt > 0) begin
            repeat (m_dwl) plan.push_back('{r, K_UP, 1'b0});
            if (r == m_tgt) break;
            r = (r + m_stp > m_tgt) ? m_tgt : r + m_stp;
         end
         plan.push_back('{m_tgt, K_HOLD, 1'b1});
      end
      if (plan.size() > 0) begin
         cur = plan.pop_front();
      end else if (cur.kind == K_HOLD && !stopped) begin
         cur.pulse = 1'b0;
      end else begin
         cur = '{0, K_IDLE, 1'b0};
      end
   endfunction

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic compare_all();
      check_eq("toggle_rate", 32'(toggle_rate), 32'(cur.rate));
      check_eq("load_rst", 32'(load_rst), 32'(cur.kind == K_PRE));
      check_eq("busy", 32'(busy), 32'(cur.kind != K_IDLE));
      check_eq("at_target", 32'(at_target), 32'(cur.kind == K_HOLD));
      check_eq("done", 32'(done), 32'(cur.pulse));
   endtask

   // One clock: model advances on the edge, outputs compared mid-cycle.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic set_profile(input int t, input int s, input int d);
      target_rate  = RATE_W'(t);
      step_rate    = RATE_W'(s);
      dwell_cycles = DWELL_W'(d);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      abort = 1'b0;
      set_profile(0, 0, 0);
      model_reset();
      repeat (3) @(negedge clk);
      compare_all();
      rst = 1'b0;
      tick();

      // Ramp up 10/4/3 with a stop edge in PRERST and a start edge while busy.
      set_profile(10, 4, 3);
      start = 1'b1;
      tick();
      for (int i = 0; i < RST_HOLD; i++) begin
         check_eq("prerst_load_rst", 32'(load_rst), 32'd1);
         if (i == 1) stop = 1'b1;
         tick();
      end
      for (int i = 0; i < 9; i++) begin
         check_eq("ramp_up_rate", 32'(toggle_rate), 32'(up_exp[i]));
         if (i == 2) start = 1'b0;
         if (i == 4) start = 1'b1;
         tick();
      end
      check_eq("hold_at_target", 32'(at_target), 32'd1);
      check_eq("hold_done", 32'(done), 32'd1);
      tick();
      check_eq("done_single", 32'(done), 32'd0);

      // Ramp down from HOLD.
      stop = 1'b0;
      tick();
      stop = 1'b1;
      tick();
      for (int i = 0; i < 9; i++) begin
         check_eq("ramp_down_rate", 32'(toggle_rate), 32'(down_exp[i]));
         tick();
      end
      check_eq("down_idle_busy", 32'(busy), 32'd0);

      // Clamp and zero defaults: 127/0/0 -> +1 per cycle up to 100.
      start = 1'b0;
      tick();
      set_profile(127, 0, 0);
      start = 1'b1;
      tick();
      repeat (RST_HOLD) tick();
      for (int i = 0; i < 100; i++) begin
         check_eq("clamp_ramp", 32'(toggle_rate), 32'(i + 1));
         tick();
      end
      check_eq("clamp_hold_rate", 32'(toggle_rate), 32'd100);
      check_eq("clamp_at_target", 32'(at_target), 32'd1);

      // Abort mid-UP at rate 8 in the last dwell cycle.
      abort = 1'b1;
      stop = 1'b0;
      tick();
      abort = 1'b0;
      start = 1'b0;
      tick();
      set_profile(10, 4, 3);
      start = 1'b1;
      tick();
      repeat (RST_HOLD + 3) tick();
      check_eq("pre_abort_rate", 32'(toggle_rate), 32'd8);
      repeat (2) tick();
      abort = 1'b1;
      tick();
      check_eq("abort_rate", 32'(toggle_rate), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_done", 32'(done), 32'd0);
      abort = 1'b0;
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      check_eq("restart_load_rst", 32'(load_rst), 32'd1);

      // Stop edge in UP at rate 8 -> DOWN at 4.
      repeat (RST_HOLD + 3) tick();
      check_eq("up_rate_8", 32'(toggle_rate), 32'd8);
      stop = 1'b1;
      tick();
      check_eq("stop_in_up", 32'(toggle_rate), 32'd4);
      repeat (15) tick();
      check_eq("stop_up_idle", 32'(busy), 32'd0);

      // Async reset between edges while holding.
      stop = 1'b0;
      start = 1'b0;
      tick();
      set_profile(3, 3, 1);
      start = 1'b1;
      tick();
      repeat (10) tick();
      check_eq("pre_reset_hold", 32'(at_target), 32'd1);
      start = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_rst_rate", 32'(toggle_rate), 32'd0);
      check_eq("async_rst_busy", 32'(busy), 32'd0);
      check_eq("async_rst_at_target", 32'(at_target), 32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Randomized command traffic.
      for (int it = 0; it < 40; it++) begin
         for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 24) == 0) start = ~start;
            if ($urandom_range(0, 39) == 0) stop = ~stop;
            abort = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 9) == 0) begin
               if ($urandom_range(0, 3) == 0) begin
                  target_rate = RATE_W'($urandom_range(0, 10));
               end else begin
                  target_rate = RATE_W'($urandom_range(0, 127));
               end
               step_rate    = RATE_W'($urandom_range(0, 25));
               dwell_cycles = DWELL_W'($urandom_range(0, 4));
            end
            tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
